// File: rtl/dds_pkg.sv
// Shared definitions for the DDS generator and the signal_meter receive path.
// Samples are unsigned offset-binary, so midscale is the zero crossing.
package dds_pkg;

  localparam logic [15:0] MID_DEFAULT  = 16'h8000;
  localparam logic [15:0] HYST_DEFAULT = 16'd1024;

  typedef enum logic [1:0] {
    ST_SEEK = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } meter_state_e;

endpackage

// File: rtl/signal_meter_schmitt.sv
// Hysteresis midscale crossing detector. Thresholds saturate at the sample range.
// level is the post-update level for the current sample; rise/fall flag a flip
// caused by the current valid sample.
module signal_meter_schmitt
  import dds_pkg::*;
#(
  parameter int unsigned        DATA_W = 16,
  parameter logic [DATA_W-1:0]  MID    = MID_DEFAULT,
  parameter logic [DATA_W-1:0]  HYST   = HYST_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              level,
  output logic              rise,
  output logic              fall
);

  localparam logic [DATA_W:0]   HI_SUM = {1'b0, MID} + {1'b0, HYST};
  localparam logic [DATA_W-1:0] HI_TH  = HI_SUM[DATA_W] ? '1 : HI_SUM[DATA_W-1:0];
  localparam logic [DATA_W-1:0] LO_TH  = (HYST > MID) ? '0 : (MID - HYST);

  logic level_d, level_q;

  // Next level: set above the upper threshold, clear below the lower, else hold
  always_comb begin
    level_d = level_q;
    if (sample_valid) begin
      if (sample_in >= HI_TH) begin
        level_d = 1'b1;
      end else if (sample_in < LO_TH) begin
        level_d = 1'b0;
      end
    end
  end

  // Level register
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

  assign level = level_d;
  assign rise  = ~level_q & level_d;
  assign fall  = level_q & ~level_d;

  // A single sample can never flip the level both ways
  a_no_double_flip: assert property (@(posedge clk) disable iff (reset) !(rise && fall));

endmodule

// File: rtl/signal_meter.sv
// Per-cycle period / high-time / peak meter on a sampled waveform.
// Optional macro SIGNAL_METER_PEAK_EN builds the peak trackers; without it
// PeakMax/PeakMin are constant 0.
module signal_meter
  import dds_pkg::*;
#(
  parameter int unsigned        DATA_W         = 16,
  parameter int unsigned        CNT_W          = 32,
  parameter logic [DATA_W-1:0]  MID            = MID_DEFAULT,
  parameter logic [DATA_W-1:0]  HYST           = HYST_DEFAULT,
  parameter logic [CNT_W-1:0]   TIMEOUT_CYCLES = 32'd50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] SampleIn,
  input  logic              SampleValid,
  output logic [CNT_W-1:0]  Period,
  output logic [CNT_W-1:0]  HighTime,
  output logic [DATA_W-1:0] PeakMax,
  output logic [DATA_W-1:0] PeakMin,
  output logic              MeasValid,
  output logic              NoSignal
);

  logic level, rise, fall;

  signal_meter_schmitt #(
    .DATA_W (DATA_W),
    .MID    (MID),
    .HYST   (HYST)
  ) u_schmitt (
    .clk          (clk),
    .reset        (reset),
    .sample_in    (SampleIn),
    .sample_valid (SampleValid),
    .level        (level),
    .rise         (rise),
    .fall         (fall)
  );

  meter_state_e     state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] hcnt_d, hcnt_q;
  logic [CNT_W-1:0] idle_d, idle_q;
  logic [CNT_W-1:0] period_d, period_q;
  logic [CNT_W-1:0] high_time_d, high_time_q;
  logic             meas_valid_d, meas_valid_q;
  logic             no_signal_d, no_signal_q;

  // Crossing-driven FSM: counting, result capture and idle timeout
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hcnt_d       = hcnt_q;
    idle_d       = idle_q;
    period_d     = period_q;
    high_time_d  = high_time_q;
    meas_valid_d = 1'b0;
    no_signal_d  = no_signal_q;
    if (SampleValid) begin
      unique case (state_q)
        ST_SEEK: begin
          if (!level) begin
            state_d = ST_ARM;
            idle_d  = '0;
          end
        end
        ST_ARM, ST_MEAS: begin
          if (rise) begin
            if (state_q == ST_MEAS) begin
              period_d     = cnt_q;
              high_time_d  = hcnt_q;
              meas_valid_d = 1'b1;
              no_signal_d  = 1'b0;
            end
            cnt_d   = CNT_W'(1);
            hcnt_d  = CNT_W'(1);
            idle_d  = '0;
            state_d = ST_MEAS;
          end else begin
            idle_d = idle_q + CNT_W'(1);
            if (state_q == ST_MEAS) begin
              cnt_d = cnt_q + CNT_W'(1);
              if (level) begin
                hcnt_d = hcnt_q + CNT_W'(1);
              end
            end
            if (idle_d == TIMEOUT_CYCLES) begin
              state_d     = ST_SEEK;
              no_signal_d = 1'b1;
            end
          end
        end
        default: state_d = ST_SEEK;
      endcase
    end
  end

  // State and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_SEEK;
      cnt_q        <= '0;
      hcnt_q       <= '0;
      idle_q       <= '0;
      period_q     <= '0;
      high_time_q  <= '0;
      meas_valid_q <= 1'b0;
      no_signal_q  <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hcnt_q       <= hcnt_d;
      idle_q       <= idle_d;
      period_q     <= period_d;
      high_time_q  <= high_time_d;
      meas_valid_q <= meas_valid_d;
      no_signal_q  <= no_signal_d;
    end
  end

  assign Period    = period_q;
  assign HighTime  = high_time_q;
  assign MeasValid = meas_valid_q;
  assign NoSignal  = no_signal_q;

`ifdef SIGNAL_METER_PEAK_EN
  logic              in_cycle, peak_load, peak_track, peak_cap;
  logic [DATA_W-1:0] pmax_d, pmax_q, pmin_d, pmin_q;
  logic [DATA_W-1:0] peak_max_d, peak_max_q, peak_min_d, peak_min_q;

  assign in_cycle   = SampleValid && (state_q == ST_ARM || state_q == ST_MEAS);
  assign peak_load  = in_cycle && rise;
  assign peak_cap   = peak_load && (state_q == ST_MEAS);
  assign peak_track = SampleValid && !rise && (state_q == ST_MEAS);

  // Running extremes within the cycle, captured alongside Period
  always_comb begin
    pmax_d     = pmax_q;
    pmin_d     = pmin_q;
    peak_max_d = peak_max_q;
    peak_min_d = peak_min_q;
    if (peak_cap) begin
      peak_max_d = pmax_q;
      peak_min_d = pmin_q;
    end
    if (peak_load) begin
      pmax_d = SampleIn;
      pmin_d = SampleIn;
    end else if (peak_track) begin
      if (SampleIn > pmax_q) pmax_d = SampleIn;
      if (SampleIn < pmin_q) pmin_d = SampleIn;
    end
  end

  // Peak tracker and peak result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pmax_q     <= '0;
      pmin_q     <= '0;
      peak_max_q <= '0;
      peak_min_q <= '0;
    end else begin
      pmax_q     <= pmax_d;
      pmin_q     <= pmin_d;
      peak_max_q <= peak_max_d;
      peak_min_q <= peak_min_d;
    end
  end

  assign PeakMax = peak_max_q;
  assign PeakMin = peak_min_q;
`else
  assign PeakMax = '0;
  assign PeakMin = '0;
`endif

endmodule
